// File: rtl/byte_joining_param.sv
// Parametrised lane-to-stream byte joiner: captures one word of LANES lane symbols
// and replays the active lanes (1<<mode, clamped to LANES) in lane order.
module byte_joining_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [LANES*WIDTH-1:0]   lanes_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int unsigned IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned NW = $clog2(LANES + 1);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t                 state;
    logic [LANES*WIDTH-1:0] buffer;
    logic [IW-1:0]          idx;
    logic [NW-1:0]          nl_q;
    logic [NW-1:0]          nl;
    logic                   last;
    logic                   accept;
    logic                   emit;

    function automatic logic [WIDTH-1:0] lane_of(input logic [LANES*WIDTH-1:0] w,
                                                 input int unsigned k);
        return w[k*WIDTH +: WIDTH];
    endfunction

    // Requested lane count clamped to the physical lane count.
    assign nl = ((32'd1 << mode) > LANES) ? NW'(LANES) : NW'(32'd1 << mode);

    assign last     = (NW'(idx) == (nl_q - NW'(1)));
    assign in_ready = (state == EMPTY) || (out_ready && last);
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    // Capture-and-replay state machine; data_out always mirrors buffer[idx] while FULL.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= EMPTY;
            buffer    <= '0;
            idx       <= '0;
            nl_q      <= NW'(1);
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= FULL;
                        buffer    <= lanes_in;
                        nl_q      <= nl;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        data_out  <= lanes_in[WIDTH-1:0];
                    end
                end
                FULL: begin
                    if (emit) begin
                        if (!last) begin
                            idx      <= idx + IW'(1);
                            data_out <= lane_of(buffer, 32'(idx) + 32'd1);
                        end else if (accept) begin
                            // Back-to-back capture on the last-byte edge avoids a bubble.
                            buffer    <= lanes_in;
                            nl_q      <= nl;
                            idx       <= '0;
                            out_valid <= 1'b1;
                            data_out  <= lanes_in[WIDTH-1:0];
                        end else begin
                            state     <= EMPTY;
                            idx       <= '0;
                            out_valid <= 1'b0;
                            data_out  <= '0;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_joining_param.sv
// Scoreboard bench for byte_joining_param: LANES=4 main instance plus LANES=8 and
// LANES=2 instances exercising the x8 mode and its clamping.
module tb_byte_joining_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_L;
    logic [1:0]  m3 = 2'd3;
    logic        rdy = 1'b1;

    logic [31:0] lanes4;
    logic        iv4, ir4, ov4, or4;
    logic [1:0]  mode4;
    logic [7:0]  do4;

    logic [63:0] lanes8;
    logic        iv8, ir8, ov8;
    logic [7:0]  do8;

    logic [15:0] lanes2;
    logic        iv2, ir2, ov2;
    logic [7:0]  do2;

    byte_joining_param #(.WIDTH(8), .LANES(4)) u4 (
        .clk(clk), .reset_L(reset_L), .lanes_in(lanes4), .in_valid(iv4), .in_ready(ir4),
        .mode(mode4), .data_out(do4), .out_valid(ov4), .out_ready(or4));

    byte_joining_param #(.WIDTH(8), .LANES(8)) u8 (
        .clk(clk), .reset_L(reset_L), .lanes_in(lanes8), .in_valid(iv8), .in_ready(ir8),
        .mode(m3), .data_out(do8), .out_valid(ov8), .out_ready(rdy));

    byte_joining_param #(.WIDTH(8), .LANES(2)) u2 (
        .clk(clk), .reset_L(reset_L), .lanes_in(lanes2), .in_valid(iv2), .in_ready(ir2),
        .mode(m3), .data_out(do2), .out_valid(ov2), .out_ready(rdy));

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] q4[$];
    logic [7:0] q8[$];
    logic [7:0] q2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic extra(input string name, input logic [7:0] act);
        n_cmp++;
        n_err++;
        $display("FAIL %s: unexpected byte %h, expected none at %0t", name, act, $time);
    endtask

    // Monitors: pop on emit, peek while stalled (data must hold).
    always @(negedge clk) begin
        if (reset_L === 1'b1 && ov4 === 1'b1) begin
            if (q4.size() == 0) extra("dut4 byte", do4);
            else if (or4) chk("dut4 byte", 32'(do4), 32'(q4.pop_front()));
            else chk("dut4 hold", 32'(do4), 32'(q4[0]));
        end
    end

    always @(negedge clk) begin
        if (reset_L === 1'b1 && ov8 === 1'b1) begin
            if (q8.size() == 0) extra("dut8 byte", do8);
            else chk("dut8 byte", 32'(do8), 32'(q8.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (reset_L === 1'b1 && ov2 === 1'b1) begin
            if (q2.size() == 0) extra("dut2 byte", do2);
            else chk("dut2 byte", 32'(do2), 32'(q2.pop_front()));
        end
    end

    // Presents a word to the LANES=4 instance, pushes its active lanes once accepted.
    task automatic send4(input logic [31:0] w, input logic [1:0] m, output int waits);
        int nl;
        lanes4 = w;
        mode4  = m;
        iv4    = 1'b1;
        waits  = 0;
        @(negedge clk);
        while (!ir4 && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!ir4) begin
            extra("dut4 accept timeout", 8'h00);
        end else begin
            nl = ((1 << m) > 4) ? 4 : (1 << m);
            for (int k = 0; k < nl; k++) q4.push_back(w[k*8 +: 8]);
        end
        @(posedge clk);
        #1;
    endtask

    // Same for the LANES=8 (sel=8) or LANES=2 (otherwise) instances, mode fixed at x8.
    task automatic send_x(input int sel, input logic [63:0] w);
        int waits;
        int nl;
        logic rd;
        waits = 0;
        nl = (sel == 8) ? 8 : 2;
        if (sel == 8) begin lanes8 = w; iv8 = 1'b1; end
        else begin lanes2 = w[15:0]; iv2 = 1'b1; end
        @(negedge clk);
        rd = (sel == 8) ? ir8 : ir2;
        while (!rd && waits < 50) begin
            waits++;
            @(negedge clk);
            rd = (sel == 8) ? ir8 : ir2;
        end
        if (!rd) begin
            extra("dutx accept timeout", 8'h00);
        end else begin
            for (int k = 0; k < nl; k++) begin
                if (sel == 8) q8.push_back(w[k*8 +: 8]);
                else q2.push_back(w[k*8 +: 8]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q8.size() != 0 || q2.size() != 0) && n < 50) begin
            n++;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        reset_L = 1'b0;
        or4 = 1'b1; mode4 = 2'd2; iv4 = 1'b0; lanes4 = '0;
        iv8 = 1'b0; lanes8 = '0; iv2 = 1'b0; lanes2 = '0;

        // Reset state, during and after release
        #2;
        chk("reset out_valid", 32'(ov4), 32'd0);
        chk("reset data_out", 32'(do4), 32'd0);
        chk("reset in_ready", 32'(ir4), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset_L = 1'b1;
        @(posedge clk);
        #1;
        chk("idle out_valid", 32'(ov4), 32'd0);
        chk("idle data_out", 32'(do4), 32'd0);
        chk("idle in_ready", 32'(ir4), 32'd1);

        // x4 single word: valid for exactly 4 cycles after the accept edge
        send4(32'h44332211, 2'd2, w);
        iv4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("x4 out_valid burst", 32'(ov4), 32'd1);
        end
        @(negedge clk);
        chk("x4 out_valid after", 32'(ov4), 32'd0);
        drain();

        // x1 sustained stream: in_ready never drops
        for (int k = 1; k <= 5; k++) begin
            send4(32'hEEDDCC00 | 32'(k), 2'd0, w);
            chk("x1 in_ready waits", 32'(w), 32'd0);
        end
        iv4 = 1'b0;
        drain();

        // x2 back-to-back with a 3-cycle stall on the second byte
        fork
            begin
                send4(32'h0000BBAA, 2'd1, w);
                send4(32'h0000DDCC, 2'd1, w);
                iv4 = 1'b0;
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (do4 !== 8'hAA && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1 or4 = 1'b0;
                repeat (3) @(posedge clk);
                #1 or4 = 1'b1;
            end
        join
        drain();

        // Mode change mid-word only affects the next capture
        send4(32'h44332211, 2'd2, w);
        send4(32'hDDCCBBAA, 2'd0, w);
        iv4 = 1'b0;
        drain();

        // x8 request on 4 lanes clamps to 4
        send4(32'hA4A3A2A1, 2'd3, w);
        iv4 = 1'b0;
        drain();

        // Asynchronous reset after the second byte is emitted
        send4(32'h44332211, 2'd2, w);
        iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_L = 1'b0;
        q4.delete();
        #1;
        chk("async reset out_valid", 32'(ov4), 32'd0);
        chk("async reset data_out", 32'(do4), 32'd0);
        @(posedge clk);
        #1 reset_L = 1'b1;
        send4(32'h88776655, 2'd2, w);
        iv4 = 1'b0;
        drain();

        // LANES=8 full sweep and LANES=2 clamp
        send_x(8, 64'h0807060504030201);
        iv8 = 1'b0;
        send_x(2, 64'h00000000_0000B2B1);
        send_x(2, 64'h00000000_0000C2C1);
        iv2 = 1'b0;
        drain();

        chk("q4 drained", 32'(q4.size()), 32'd0);
        chk("q8 drained", 32'(q8.size()), 32'd0);
        chk("q2 drained", 32'(q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
